// File: rtl/glitc_trig_pkg.sv
// Shared types and constants for the GLITC correlator trigger path.
// Debug field offsets describe debug_o when CORR_TRIG_DEBUG_EN is defined.
package glitc_trig_pkg;

  localparam int CORR_WIDTH_DEF = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ABOVE   = 2'd1,
    HOLDOFF = 2'd2
  } trig_state_t;

  localparam int DBG_CORR_LSB   = 0;
  localparam int DBG_FORCED_BIT = 12;
  localparam int DBG_TRIG_BIT   = 13;
  localparam int DBG_STATE_LSB  = 14;

endpackage

// File: rtl/trig_rate_scaler.sv
// Windowed trigger-rate scaler: free-running gate, saturating count.
// The tick arriving on the last window cycle is folded into that window.
module trig_rate_scaler
  import glitc_trig_pkg::*;
#(
  parameter int SCALER_WIDTH       = 16,
  parameter int SCALER_WINDOW_LOG2 = 14
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    tick,
  output logic [SCALER_WIDTH-1:0] count,
  output logic                    valid
);

  logic [SCALER_WINDOW_LOG2-1:0] win;
  logic [SCALER_WIDTH-1:0]       acc;
  logic [SCALER_WIDTH-1:0]       acc_nxt;
  logic                          last;

  assign last    = &win;
  assign acc_nxt = (tick && !(&acc)) ? acc + 1'b1 : acc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win   <= '0;
      acc   <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      win   <= win + 1'b1;
      valid <= last;
      if (last) begin
        count <= acc_nxt;
        acc   <= '0;
      end else begin
        acc <= acc_nxt;
      end
    end
  end

endmodule

// File: rtl/corr_trigger_gen.sv
// Threshold/peak trigger on single_corr_v6 output with holdoff and scaler.
// Define CORR_TRIG_DEBUG_EN to register the ILA debug bus on debug_o.
module corr_trigger_gen
  import glitc_trig_pkg::*;
#(
  parameter int CORR_WIDTH         = CORR_WIDTH_DEF,
  parameter int PEAK_MAX_LEN       = 16,
  parameter int SCALER_WIDTH       = 16,
  parameter int SCALER_WINDOW_LOG2 = 14
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [CORR_WIDTH-1:0]   corr_i,
  input  logic [CORR_WIDTH-1:0]   threshold_i,
  input  logic [7:0]              holdoff_i,
  output logic                    trig_o,
  output logic [CORR_WIDTH-1:0]   trig_peak_o,
  output logic                    trig_forced_o,
  output logic [SCALER_WIDTH-1:0] scaler_o,
  output logic                    scaler_valid_o,
  output logic [15:0]             debug_o
);

  localparam logic [7:0] MAX_LEN = 8'(PEAK_MAX_LEN);

  trig_state_t           state;
  logic [CORR_WIDTH-1:0] peak;
  logic [CORR_WIDTH-1:0] peak_nxt;
  logic [CORR_WIDTH-1:0] fire_peak;
  logic [7:0]            len;
  logic [7:0]            len_nxt;
  logic [7:0]            hcnt;
  logic                  over;
  logic                  fire;
  logic                  fire_forced;

  always_comb begin
    over        = corr_i > threshold_i;
    peak_nxt    = (corr_i > peak) ? corr_i : peak;
    len_nxt     = len + 8'd1;
    fire        = 1'b0;
    fire_forced = 1'b0;
    fire_peak   = peak_nxt;
    if (enable_i) begin
      unique case (state)
        IDLE: begin
          // A one-sample max length fires straight from the arming sample
          if (over && MAX_LEN == 8'd1) begin
            fire        = 1'b1;
            fire_forced = 1'b1;
            fire_peak   = corr_i;
          end
        end
        ABOVE: begin
          if (!over) begin
            fire      = 1'b1;
            fire_peak = peak;
          end else if (len_nxt == MAX_LEN) begin
            fire        = 1'b1;
            fire_forced = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      peak          <= '0;
      len           <= '0;
      hcnt          <= '0;
      trig_o        <= 1'b0;
      trig_forced_o <= 1'b0;
      trig_peak_o   <= '0;
    end else begin
      trig_o        <= fire;
      trig_forced_o <= fire_forced;
      if (fire) trig_peak_o <= fire_peak;
      if (!enable_i) begin
        state <= IDLE;
      end else if (fire) begin
        if (holdoff_i == 8'd0) begin
          state <= IDLE;
        end else begin
          state <= HOLDOFF;
          hcnt  <= holdoff_i;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (over) begin
              state <= ABOVE;
              peak  <= corr_i;
              len   <= 8'd1;
            end
          end
          ABOVE: begin
            peak <= peak_nxt;
            len  <= len_nxt;
          end
          HOLDOFF: begin
            hcnt <= hcnt - 8'd1;
            if (hcnt == 8'd1) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  trig_rate_scaler #(
    .SCALER_WIDTH       (SCALER_WIDTH),
    .SCALER_WINDOW_LOG2 (SCALER_WINDOW_LOG2)
  ) u_scaler (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tick  (trig_o),
    .count (scaler_o),
    .valid (scaler_valid_o)
  );

`ifdef CORR_TRIG_DEBUG_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      debug_o <= '0;
    end else begin
      debug_o[DBG_STATE_LSB +: 2]   <= state;
      debug_o[DBG_TRIG_BIT]         <= trig_o;
      debug_o[DBG_FORCED_BIT]       <= trig_forced_o;
      debug_o[DBG_CORR_LSB +: 12]   <= corr_i[11:0];
    end
  end
`else
  assign debug_o = '0;
`endif

endmodule
